pu_msp430_dbg_halt_ctl: RTL and testbench

PU_MSP430_DBG_HALT_CTL -- requirements
Module: pu_msp430_dbg_halt_ctl

---
 rtl/pu_msp430_dbg_halt_ctl_pkg.sv | 31 +++
 rtl/pu_msp430_dbg_halt_ctl.sv | 162 ++++++++++++++++
 tb/tb_pu_msp430_dbg_halt_ctl.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/pu_msp430_dbg_halt_ctl_pkg.sv
// Purpose: shared debug-unit definitions (CPU_CTL/CPU_STAT bit map, halt FSM states).
// Latency: n/a (definitions only).
// Backpressure: n/a.
package pu_msp430_dbg_halt_ctl_pkg;

    // CPU_CTL bit positions: [2:0] are write-only command strobes, [6:3] are stored.
    localparam int CTL_HALT       = 0;
    localparam int CTL_RUN        = 1;
    localparam int CTL_ISTEP      = 2;
    localparam int CTL_SW_BRK_EN  = 3;
    localparam int CTL_FRZ_BRK_EN = 4;
    localparam int CTL_RST_BRK_EN = 5;
    localparam int CTL_CPU_RST    = 6;

    // CPU_STAT bit positions
    localparam int STAT_HALT_RUN   = 0;
    localparam int STAT_PUC_PND    = 2;
    localparam int STAT_SWBRK_PND  = 3;
    localparam int STAT_HWBRK_LSB  = 4;

    // Opcode reserved as the software breakpoint instruction
    localparam logic [15:0] SWBRK_OPCODE = 16'h4343;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_HALT_REQ = 2'd1,
        ST_HALTED   = 2'd2,
        ST_STEP     = 2'd3
    } halt_state_e;

endpackage

// File: rtl/pu_msp430_dbg_halt_ctl.sv
// Purpose: debug halt/run/single-step controller with CPU_CTL and CPU_STAT registers.
// Latency: dbg_halt_cmd is registered, asserted 1 cycle after the triggering event; reads are combinational.
// Backpressure: none; register strobes and events are accepted every cycle.
//
// Ports:
//   dbg_clk, dbg_rst_n            clock, async active-low reset
//   brk_halt, brk_pnd             per hardware-breakpoint-unit halt request / pending flags
//   cpu_ctl_wr/rd, cpu_stat_wr/rd register write strobes and read selects, write data dbg_din
//   decode_noirq, ir              frontend decode strobe and instruction register
//   dbg_halt_st, puc_pnd_set      CPU halted status, PUC pending pulse
//   dbg_halt_cmd, dbg_cpu_reset,
//   dbg_freeze, halt_dout         halt command, CPU reset, peripheral freeze, register read data
module pu_msp430_dbg_halt_ctl
    import pu_msp430_dbg_halt_ctl_pkg::*;
#(
    parameter int NB_HWBRK = 4
) (
    input  logic                dbg_clk,
    input  logic                dbg_rst_n,
    input  logic [NB_HWBRK-1:0] brk_halt,
    input  logic [NB_HWBRK-1:0] brk_pnd,
    input  logic                cpu_ctl_wr,
    input  logic                cpu_ctl_rd,
    input  logic                cpu_stat_wr,
    input  logic                cpu_stat_rd,
    input  logic [15:0]         dbg_din,
    input  logic                decode_noirq,
    input  logic [15:0]         ir,
    input  logic                dbg_halt_st,
    input  logic                puc_pnd_set,
    output logic                dbg_halt_cmd,
    output logic                dbg_cpu_reset,
    output logic                dbg_freeze,
    output logic [15:0]         halt_dout
);

    halt_state_e state_q, state_nxt;

    logic sw_brk_en, frz_brk_en, rst_brk_en, cpu_rst;
    logic puc_pnd, swbrk_pnd;
    logic halt_cmd_nxt;

    // Only CPU_CTL[6:0] is implemented; the upper write-data bits are ignored.
    logic unused_din_hi;
    assign unused_din_hi = ^dbg_din[15:7];

    // Command strobes
    logic halt_stb, run_stb, istep_stb;
    assign halt_stb  = cpu_ctl_wr & dbg_din[CTL_HALT];
    assign run_stb   = cpu_ctl_wr & dbg_din[CTL_RUN];
    assign istep_stb = cpu_ctl_wr & dbg_din[CTL_ISTEP];

    // Halt sources
    logic sw_brk_evt, halt_trig;
    assign sw_brk_evt = decode_noirq & (ir == SWBRK_OPCODE) & sw_brk_en;
    assign halt_trig  = halt_stb | (|brk_halt) | sw_brk_evt | (puc_pnd_set & rst_brk_en);

    // Stored CPU_CTL bits
    always_ff @(posedge dbg_clk or negedge dbg_rst_n) begin
        if (!dbg_rst_n) begin
            sw_brk_en  <= 1'b0;
            frz_brk_en <= 1'b0;
            rst_brk_en <= 1'b0;
            cpu_rst    <= 1'b0;
        end else if (cpu_ctl_wr) begin
            sw_brk_en  <= dbg_din[CTL_SW_BRK_EN];
            frz_brk_en <= dbg_din[CTL_FRZ_BRK_EN];
            rst_brk_en <= dbg_din[CTL_RST_BRK_EN];
            cpu_rst    <= dbg_din[CTL_CPU_RST];
        end
    end

    // Sticky pending flags, write-1-to-clear; a new event in the clear cycle is kept.
    always_ff @(posedge dbg_clk or negedge dbg_rst_n) begin
        if (!dbg_rst_n) begin
            puc_pnd   <= 1'b0;
            swbrk_pnd <= 1'b0;
        end else begin
            if (puc_pnd_set)
                puc_pnd <= 1'b1;
            else if (cpu_stat_wr & dbg_din[STAT_PUC_PND])
                puc_pnd <= 1'b0;

            if (sw_brk_evt)
                swbrk_pnd <= 1'b1;
            else if (cpu_stat_wr & dbg_din[STAT_SWBRK_PND])
                swbrk_pnd <= 1'b0;
        end
    end

    // FSM state and halt command registers
    always_ff @(posedge dbg_clk or negedge dbg_rst_n) begin
        if (!dbg_rst_n) begin
            state_q      <= ST_RUN;
            dbg_halt_cmd <= 1'b0;
        end else begin
            state_q      <= state_nxt;
            dbg_halt_cmd <= halt_cmd_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        unique case (state_q)
            ST_RUN: begin
                if (halt_trig)
                    state_nxt = ST_HALT_REQ;
            end
            ST_HALT_REQ: begin
                // An explicit RUN cancels a pending request even if the CPU
                // reports halted in the same cycle, so the command is not lost.
                if (run_stb && !halt_stb)
                    state_nxt = ST_RUN;
                else if (dbg_halt_st)
                    state_nxt = ST_HALTED;
            end
            ST_HALTED: begin
                if (halt_stb)
                    state_nxt = ST_HALTED;
                else if (run_stb)
                    state_nxt = ST_RUN;
                else if (istep_stb)
                    state_nxt = ST_STEP;
            end
            ST_STEP: begin
                // The step is complete once one instruction has been decoded;
                // any breakpoint or HALT cuts it short the same way.
                if (halt_trig || decode_noirq)
                    state_nxt = ST_HALT_REQ;
            end
            default: state_nxt = ST_RUN;
        endcase
        halt_cmd_nxt = (state_nxt == ST_HALT_REQ) || (state_nxt == ST_HALTED);
    end

    assign dbg_freeze    = frz_brk_en & dbg_halt_st;
    assign dbg_cpu_reset = cpu_rst;

    // Register read data
    logic [3:0]  hwbrk_pnd;
    logic [15:0] ctl_rdata, stat_rdata;

    always_comb begin
        hwbrk_pnd                 = '0;
        hwbrk_pnd[NB_HWBRK-1:0]   = brk_pnd;

        ctl_rdata                 = '0;
        ctl_rdata[CTL_SW_BRK_EN]  = sw_brk_en;
        ctl_rdata[CTL_FRZ_BRK_EN] = frz_brk_en;
        ctl_rdata[CTL_RST_BRK_EN] = rst_brk_en;
        ctl_rdata[CTL_CPU_RST]    = cpu_rst;

        stat_rdata                          = '0;
        stat_rdata[STAT_HALT_RUN]           = dbg_halt_st;
        stat_rdata[STAT_PUC_PND]            = puc_pnd;
        stat_rdata[STAT_SWBRK_PND]          = swbrk_pnd;
        stat_rdata[STAT_HWBRK_LSB +: 4]     = hwbrk_pnd;
    end

    assign halt_dout = (ctl_rdata & {16{cpu_ctl_rd}}) | (stat_rdata & {16{cpu_stat_rd}});

endmodule

// File: tb/tb_pu_msp430_dbg_halt_ctl.sv
module tb_pu_msp430_dbg_halt_ctl;

    logic        dbg_clk = 1'b0;
    logic        dbg_rst_n;
    logic [3:0]  brk_halt, brk_pnd;
    logic        cpu_ctl_wr, cpu_ctl_rd, cpu_stat_wr, cpu_stat_rd;
    logic [15:0] dbg_din, ir;
    logic        decode_noirq, dbg_halt_st, puc_pnd_set;
    logic        dbg_halt_cmd, dbg_cpu_reset, dbg_freeze;
    logic [15:0] halt_dout;

    pu_msp430_dbg_halt_ctl #(.NB_HWBRK(4)) dut (
        .dbg_clk       (dbg_clk),
        .dbg_rst_n     (dbg_rst_n),
        .brk_halt      (brk_halt),
        .brk_pnd       (brk_pnd),
        .cpu_ctl_wr    (cpu_ctl_wr),
        .cpu_ctl_rd    (cpu_ctl_rd),
        .cpu_stat_wr   (cpu_stat_wr),
        .cpu_stat_rd   (cpu_stat_rd),
        .dbg_din       (dbg_din),
        .decode_noirq  (decode_noirq),
        .ir            (ir),
        .dbg_halt_st   (dbg_halt_st),
        .puc_pnd_set   (puc_pnd_set),
        .dbg_halt_cmd  (dbg_halt_cmd),
        .dbg_cpu_reset (dbg_cpu_reset),
        .dbg_freeze    (dbg_freeze),
        .halt_dout     (halt_dout)
    );

    always #5 dbg_clk = ~dbg_clk;

    typedef struct {
        logic        ctl_wr, ctl_rd, stat_wr, stat_rd;
        logic [15:0] din;
        logic        dec;
        logic [15:0] ir;
        logic        hst, puc;
        logic [3:0]  bh, bp;
        logic        e_cmd, e_rst, e_frz;
        logic [15:0] e_dout;
    } vec_t;

    vec_t tbl_a[$];
    vec_t tbl_b[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    function automatic vec_t mk(
        input logic ctl_wr, input logic ctl_rd, input logic stat_wr, input logic stat_rd,
        input logic [15:0] din, input logic dec, input logic [15:0] irv,
        input logic hst, input logic puc, input logic [3:0] bh, input logic [3:0] bp,
        input logic e_cmd, input logic e_rst, input logic e_frz, input logic [15:0] e_dout);
        vec_t v;
        v.ctl_wr = ctl_wr;  v.ctl_rd = ctl_rd;  v.stat_wr = stat_wr;  v.stat_rd = stat_rd;
        v.din = din;  v.dec = dec;  v.ir = irv;  v.hst = hst;  v.puc = puc;
        v.bh = bh;  v.bp = bp;
        v.e_cmd = e_cmd;  v.e_rst = e_rst;  v.e_frz = e_frz;  v.e_dout = e_dout;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        cpu_ctl_wr   = v.ctl_wr;
        cpu_ctl_rd   = v.ctl_rd;
        cpu_stat_wr  = v.stat_wr;
        cpu_stat_rd  = v.stat_rd;
        dbg_din      = v.din;
        decode_noirq = v.dec;
        ir           = v.ir;
        dbg_halt_st  = v.hst;
        puc_pnd_set  = v.puc;
        brk_halt     = v.bh;
        brk_pnd      = v.bp;
    endtask

    task automatic check(input string name, input logic e_cmd, input logic e_rst,
                         input logic e_frz, input logic [15:0] e_dout);
        logic [18:0] act, exp;
        act = {dbg_halt_cmd, dbg_cpu_reset, dbg_freeze, halt_dout};
        exp = {e_cmd, e_rst, e_frz, e_dout};
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got cmd=%b rst=%b frz=%b dout=%h, want cmd=%b rst=%b frz=%b dout=%h",
                     name, act[18], act[17], act[16], act[15:0], exp[18], exp[17], exp[16], exp[15:0]);
        end
    endtask

    // Inputs change at the falling edge; outputs are sampled 1 time unit after the rising edge.
    task automatic apply(input vec_t v, input string name);
        @(negedge dbg_clk);
        drive(v);
        @(posedge dbg_clk);
        #1;
        check(name, v.e_cmd, v.e_rst, v.e_frz, v.e_dout);
    endtask

    // Assert reset mid-cycle with both registers selected and check outputs clear at once.
    task automatic reset_pulse(input string name);
        @(negedge dbg_clk);
        drive(mk(0,1,0,1,16'h0000,0,16'h0000,0,0,4'h0,4'h0, 0,0,0,16'h0000));
        #2 dbg_rst_n = 1'b0;
        #1 check(name, 1'b0, 1'b0, 1'b0, 16'h0000);
        @(negedge dbg_clk);
        dbg_rst_n = 1'b1;
    endtask

    initial begin
        // ctl_wr ctl_rd stat_wr stat_rd din dec ir hst puc bh bp | cmd rst frz dout
        tbl_a.push_back(mk(0,0,0,0,16'h0000,0,16'h0000,0,0,4'h0,4'h0, 0,0,0,16'h0000)); // idle in RUN
        tbl_a.push_back(mk(1,0,0,0,16'h0001,0,16'h0000,0,0,4'h0,4'h0, 1,0,0,16'h0000)); // HALT strobe
        tbl_a.push_back(mk(0,0,0,1,16'h0000,0,16'h0000,1,0,4'h0,4'h0, 1,0,0,16'h0001)); // halted, STAT=0001
        tbl_a.push_back(mk(1,0,0,1,16'h0002,0,16'h0000,1,0,4'h0,4'h0, 0,0,0,16'h0001)); // RUN strobe
        tbl_a.push_back(mk(0,0,0,0,16'h0000,0,16'h0000,0,0,4'h0,4'h0, 0,0,0,16'h0000)); // running
        tbl_a.push_back(mk(0,0,0,0,16'h0000,0,16'h0000,0,0,4'h4,4'h4, 1,0,0,16'h0000)); // hw brk unit 2
        tbl_a.push_back(mk(0,0,0,1,16'h0000,0,16'h0000,1,0,4'h0,4'h4, 1,0,0,16'h0041)); // STAT=0041
        tbl_a.push_back(mk(1,0,0,0,16'h0004,0,16'h0000,1,0,4'h0,4'h0, 0,0,0,16'h0000)); // ISTEP
        tbl_a.push_back(mk(0,0,0,0,16'h0000,0,16'h0000,0,0,4'h0,4'h0, 0,0,0,16'h0000)); // step, no decode yet
        tbl_a.push_back(mk(0,0,0,0,16'h0000,1,16'h1234,0,0,4'h0,4'h0, 1,0,0,16'h0000)); // decode ends step
        tbl_a.push_back(mk(0,0,0,0,16'h0000,0,16'h0000,1,0,4'h0,4'h0, 1,0,0,16'h0000)); // halted again
        tbl_a.push_back(mk(1,0,0,0,16'h0006,0,16'h0000,1,0,4'h0,4'h0, 0,0,0,16'h0000)); // RUN+ISTEP -> RUN
        tbl_a.push_back(mk(0,1,0,0,16'h0000,0,16'h0000,0,0,4'h0,4'h0, 0,0,0,16'h0000)); // CTL reads 0
        tbl_a.push_back(mk(1,1,0,0,16'h0008,0,16'h0000,0,0,4'h0,4'h0, 0,0,0,16'h0008)); // SW_BRK_EN
        tbl_a.push_back(mk(0,0,0,1,16'h0000,1,16'h4343,0,0,4'h0,4'h0, 1,0,0,16'h0008)); // sw breakpoint
        tbl_a.push_back(mk(0,0,0,1,16'h0000,0,16'h0000,1,0,4'h0,4'h0, 1,0,0,16'h0009)); // halted, SWBRK_PND
        tbl_a.push_back(mk(0,0,1,1,16'h0008,0,16'h0000,1,0,4'h0,4'h0, 1,0,0,16'h0001)); // W1C SWBRK_PND
        tbl_a.push_back(mk(0,0,1,1,16'h0008,1,16'h4343,1,0,4'h0,4'h0, 1,0,0,16'h0009)); // set beats clear
        tbl_a.push_back(mk(0,0,1,1,16'h0008,0,16'h0000,1,0,4'h0,4'h0, 1,0,0,16'h0001)); // clear again
        tbl_a.push_back(mk(1,0,0,0,16'h000A,0,16'h0000,0,0,4'h0,4'h0, 0,0,0,16'h0000)); // RUN, keep SW_BRK_EN
        tbl_a.push_back(mk(0,0,0,0,16'h0000,1,16'h4342,0,0,4'h0,4'h0, 0,0,0,16'h0000)); // other opcode ignored
        tbl_a.push_back(mk(1,0,0,0,16'h0003,0,16'h0000,0,0,4'h0,4'h0, 1,0,0,16'h0000)); // HALT beats RUN
        tbl_a.push_back(mk(0,0,0,0,16'h0000,0,16'h0000,1,0,4'h0,4'h0, 1,0,0,16'h0000)); // halted

        tbl_b.push_back(mk(1,1,0,0,16'h0030,0,16'h0000,0,0,4'h0,4'h0, 0,0,0,16'h0030)); // running after reset
        tbl_b.push_back(mk(0,0,0,1,16'h0000,0,16'h0000,0,1,4'h0,4'h0, 1,0,0,16'h0004)); // PUC brk
        tbl_b.push_back(mk(0,0,0,1,16'h0000,0,16'h0000,1,0,4'h0,4'h0, 1,0,1,16'h0005)); // freeze when halted
        tbl_b.push_back(mk(0,0,1,1,16'h0004,0,16'h0000,1,0,4'h0,4'h0, 1,0,1,16'h0001)); // W1C PUC_PND
        tbl_b.push_back(mk(1,1,0,0,16'h0040,0,16'h0000,1,0,4'h0,4'h0, 1,1,0,16'h0040)); // CPU_RST, FRZ off
        tbl_b.push_back(mk(1,0,0,0,16'h0002,0,16'h0000,0,0,4'h0,4'h0, 0,0,0,16'h0000)); // RUN, CPU_RST off
        tbl_b.push_back(mk(1,0,0,0,16'h0001,0,16'h0000,0,0,4'h0,4'h0, 1,0,0,16'h0000)); // HALT
        tbl_b.push_back(mk(0,0,0,0,16'h0000,0,16'h0000,1,0,4'h0,4'h0, 1,0,0,16'h0000)); // halted
        tbl_b.push_back(mk(1,0,0,0,16'h0005,0,16'h0000,1,0,4'h0,4'h0, 1,0,0,16'h0000)); // HALT+ISTEP stays
        tbl_b.push_back(mk(1,0,0,0,16'h0004,0,16'h0000,1,0,4'h0,4'h0, 0,0,0,16'h0000)); // ISTEP
        tbl_b.push_back(mk(0,0,0,1,16'h0000,0,16'h0000,0,0,4'h1,4'h1, 1,0,0,16'h0010)); // brk during step
        tbl_b.push_back(mk(1,0,0,0,16'h0002,0,16'h0000,0,0,4'h0,4'h0, 0,0,0,16'h0000)); // RUN cancels request
        tbl_b.push_back(mk(0,0,0,1,16'h0000,0,16'h0000,0,1,4'h0,4'h0, 0,0,0,16'h0004)); // PUC, no RST_BRK_EN
        tbl_b.push_back(mk(0,0,1,1,16'h0004,0,16'h0000,0,0,4'h0,4'h0, 0,0,0,16'h0000)); // W1C PUC_PND

        // Reset state
        drive(mk(0,1,0,1,16'h0000,0,16'h0000,0,0,4'h0,4'h0, 0,0,0,16'h0000));
        dbg_rst_n = 1'b0;
        #12;
        check("reset_state", 1'b0, 1'b0, 1'b0, 16'h0000);
        @(negedge dbg_clk);
        dbg_rst_n = 1'b1;

        for (int i = 0; i < tbl_a.size(); i++)
            apply(tbl_a[i], $sformatf("tbl_a[%0d]", i));

        reset_pulse("reset_while_halted");

        for (int i = 0; i < tbl_b.size(); i++)
            apply(tbl_b[i], $sformatf("tbl_b[%0d]", i));

        // Reset in the middle of a single step: the step is abandoned and the
        // CPU keeps running, so a later decode does not re-halt it.
        apply(mk(1,0,0,0,16'h0001,0,16'h0000,0,0,4'h0,4'h0, 1,0,0,16'h0000), "step_rst_halt");
        apply(mk(0,0,0,0,16'h0000,0,16'h0000,1,0,4'h0,4'h0, 1,0,0,16'h0000), "step_rst_halted");
        apply(mk(1,0,0,0,16'h0004,0,16'h0000,1,0,4'h0,4'h0, 0,0,0,16'h0000), "step_rst_istep");
        reset_pulse("reset_while_step");
        apply(mk(0,0,0,0,16'h0000,1,16'h1234,0,0,4'h0,4'h0, 0,0,0,16'h0000), "step_rst_decode");
        apply(mk(0,0,0,0,16'h0000,0,16'h0000,0,0,4'h0,4'h0, 0,0,0,16'h0000), "step_rst_idle");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
